// File: rtl/dfdd_result_streamer.sv
// dfdd_result_streamer: buffers the valid-only DfDD divider pixel stream and re-emits it as ready/valid
// with sof/eol markers, overflow detection and frame resync. Optional macro: DFDD_CONF_MASK_EN.
module dfdd_result_streamer #(
    parameter int EXP_WIDTH    = 0,
    parameter int FRAC_WIDTH   = 0,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int FIFO_DEPTH   = 16,
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [FP_WIDTH_REG-1:0]   z_i,
    input  logic [FP_WIDTH_REG-1:0]   c_i,
    input  logic [15:0]               col_i,
    input  logic [15:0]               row_i,
    input  logic                      valid_i,
    input  logic [FP_WIDTH_REG-1:0]   c_thresh_i,
    output logic [2*FP_WIDTH_REG-1:0] data_o,
    output logic                      sof_o,
    output logic                      eol_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      overflow_o,
    output logic                      frame_done_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 2*FP_WIDTH_REG + 3;
    localparam logic [AW:0] DEPTH_L  = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {WAIT_SOF, STREAM, DROP} state_t;
    state_t r_state, w_state_nxt;

    // entry layout: {c, z, sof, eol, last-of-frame}
    logic [EW-1:0]             r_mem [FIFO_DEPTH];
    logic [AW-1:0]             r_wr_ptr, r_rd_ptr;
    logic [AW:0]               r_count;

    logic [2*FP_WIDTH_REG-1:0] r_data;
    logic                      r_sof, r_eol, r_last, r_valid, r_ovf, r_fd;

    logic                      w_is_sof, w_is_eol, w_is_last;
    logic                      w_fifo_pop, w_room, w_push, w_drop;
    logic [FP_WIDTH_REG-1:0]   w_z_store;
    logic [EW-1:0]             w_entry;
    logic                      w_unused;

`ifdef DFDD_CONF_MASK_EN
    // c is never negative, so the magnitude bits order like an unsigned integer
    assign w_z_store = (c_i[FP_WIDTH_REG-2:0] < c_thresh_i[FP_WIDTH_REG-2:0]) ? '0 : z_i;
    assign w_unused  = c_thresh_i[FP_WIDTH_REG-1];
`else
    assign w_z_store = z_i;
    assign w_unused  = ^c_thresh_i;
`endif

    assign w_is_sof  = (row_i == 16'd0) && (col_i == 16'd0);
    assign w_is_eol  = (col_i == LAST_COL);
    assign w_is_last = w_is_eol && (row_i == LAST_ROW);
    assign w_entry   = {c_i, w_z_store, w_is_sof, w_is_eol, w_is_last};

    // the output register refills from the FIFO head whenever it is empty or being consumed
    assign w_fifo_pop = (r_count != '0) && (!r_valid || ready_i);
    assign w_room     = (r_count != DEPTH_L) || w_fifo_pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= WAIT_SOF;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_drop      = 1'b0;
        if (valid_i) begin
            case (r_state)
                WAIT_SOF, DROP: begin
                    if (w_is_sof) begin
                        if (w_room) begin
                            w_push      = 1'b1;
                            w_state_nxt = w_is_last ? WAIT_SOF : STREAM;
                        end else begin
                            w_drop      = 1'b1;
                            w_state_nxt = DROP;
                        end
                    end
                end
                STREAM: begin
                    if (w_room) begin
                        w_push = 1'b1;
                        if (w_is_last) w_state_nxt = WAIT_SOF;
                    end else begin
                        w_drop      = 1'b1;
                        w_state_nxt = DROP;
                    end
                end
                default: w_state_nxt = WAIT_SOF;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_fifo_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_fifo_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            r_last  <= 1'b0;
            r_ovf   <= 1'b0;
            r_fd    <= 1'b0;
        end else begin
            r_fd <= r_valid && ready_i && r_last;
            if (w_drop) r_ovf <= 1'b1;
            if (w_fifo_pop) begin
                {r_data, r_sof, r_eol, r_last} <= r_mem[r_rd_ptr];
                r_valid <= 1'b1;
            end else if (ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o       = r_data;
    assign sof_o        = r_sof;
    assign eol_o        = r_eol;
    assign valid_o      = r_valid;
    assign overflow_o   = r_ovf;
    assign frame_done_o = r_fd;
endmodule

// File: tb/tb_dfdd_result_streamer.sv
// Scoreboard bench for dfdd_result_streamer on a 4x2 image with a 4-entry FIFO.
module tb_dfdd_result_streamer;
    logic        clk = 1'b0;
    logic        rst_i, valid_i, ready_i;
    logic [15:0] z_i, c_i, col_i, row_i, c_thresh_i;
    logic [31:0] data_o;
    logic        sof_o, eol_o, valid_o, overflow_o, frame_done_o;

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eol;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   prev_stall = 1'b0;
    bit   exp_fd = 1'b0;

    always #5 clk = ~clk;

    dfdd_result_streamer #(
        .EXP_WIDTH(5), .FRAC_WIDTH(10), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .z_i(z_i), .c_i(c_i), .col_i(col_i), .row_i(row_i),
        .valid_i(valid_i), .c_thresh_i(c_thresh_i), .data_o(data_o), .sof_o(sof_o),
        .eol_o(eol_o), .valid_o(valid_o), .ready_i(ready_i), .overflow_o(overflow_o),
        .frame_done_o(frame_done_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // one input cycle; expected output pushed when the pixel should be kept
    task automatic pix(input int r, input int cl, input logic [15:0] z, input logic [15:0] c,
                       input bit push, input bit rdy);
        exp_t e;
        logic [15:0] ze;
        @(posedge clk); #1;
        valid_i = 1'b1; row_i = 16'(r); col_i = 16'(cl); z_i = z; c_i = c; ready_i = rdy;
        if (push) begin
            ze = z;
`ifdef DFDD_CONF_MASK_EN
            if (c[14:0] < c_thresh_i[14:0]) ze = 16'h0000;
`endif
            e.data = {c, ze};
            e.sof  = (r == 0) && (cl == 0);
            e.eol  = (cl == 3);
            e.last = (r == 1) && (cl == 3);
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) begin
            @(posedge clk); #1;
            valid_i = 1'b0; ready_i = rdy;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_i) begin
            prev_stall = 1'b0;
            exp_fd     = 1'b0;
        end else begin
            chk("frame_done", {63'd0, frame_done_o}, {63'd0, exp_fd});
            if (prev_stall) chk("valid_hold", {63'd0, valid_o}, 64'd1);
            exp_fd = 1'b0;
            if (valid_o) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_out: got data %0h want no output", data_o);
                end else begin
                    chk("data", {32'd0, data_o}, {32'd0, q[0].data});
                    chk("sof", {63'd0, sof_o}, {63'd0, q[0].sof});
                    chk("eol", {63'd0, eol_o}, {63'd0, q[0].eol});
                    if (ready_i) begin
                        exp_fd = q[0].last;
                        void'(q.pop_front());
                    end
                end
            end
            prev_stall = valid_o && !ready_i;
        end
    end

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; z_i = '0; c_i = '0;
        row_i = '0; col_i = '0; c_thresh_i = 16'h3800;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_data", {32'd0, data_o}, 64'd0);
        chk("rst_sof", {63'd0, sof_o}, 64'd0);
        chk("rst_eol", {63'd0, eol_o}, 64'd0);
        chk("rst_ovf", {63'd0, overflow_o}, 64'd0);
        chk("rst_fd", {63'd0, frame_done_o}, 64'd0);

        // frame pass-through with 1-cycle latency
        pix(0, 0, 16'h3C00, 16'h3800, 1, 1);
        pix(0, 1, 16'h3C00, 16'h3800, 1, 1);
        @(negedge clk); chk("lat_edge1", {63'd0, valid_o}, 64'd0);
        pix(0, 2, 16'h3C00, 16'h3800, 1, 1);
        @(negedge clk); chk("lat_edge2", {63'd0, valid_o}, 64'd1);
        for (int i = 3; i < 8; i++) pix(i / 4, i % 4, 16'h3C00, 16'h3800, 1, 1);
        idle(5, 1);

        // startup discard
        do_reset();
        pix(0, 1, 16'h0F01, 16'h3800, 0, 1);
        pix(0, 2, 16'h0F02, 16'h3800, 0, 1);
        for (int i = 0; i < 8; i++) pix(i / 4, i % 4, 16'h1000 + 16'(i), 16'h3800, 1, 1);
        idle(5, 1);
        @(negedge clk); chk("discard_ovf", {63'd0, overflow_o}, 64'd0);

        // reset mid-frame flushes buffered pixels
        for (int i = 0; i < 3; i++) pix(0, i, 16'h0E00 + 16'(i), 16'h3800, 1, 0);
        do_reset();
        @(negedge clk); chk("rst_flush", {63'd0, valid_o}, 64'd0);
        pix(1, 0, 16'h0E10, 16'h3800, 0, 1);

        // backpressure: 5 buffered, then released
        for (int i = 0; i < 5; i++) pix(i / 4, i % 4, 16'h2000 + 16'(i), 16'h3800, 1, 0);
        idle(3, 0);
        @(negedge clk); chk("bp_ovf", {63'd0, overflow_o}, 64'd0);
        for (int i = 5; i < 8; i++) pix(i / 4, i % 4, 16'h2000 + 16'(i), 16'h3800, 1, 1);
        idle(8, 1);

        // overflow: 6th pixel dropped, rest of frame discarded
        for (int i = 0; i < 5; i++) pix(i / 4, i % 4, 16'h3000 + 16'(i), 16'h3800, 1, 0);
        pix(1, 1, 16'h3005, 16'h3800, 0, 0);
        @(negedge clk); chk("ovf_before_edge", {63'd0, overflow_o}, 64'd0);
        pix(1, 2, 16'h3006, 16'h3800, 0, 0);
        @(negedge clk); chk("ovf_set", {63'd0, overflow_o}, 64'd1);
        pix(1, 3, 16'h3007, 16'h3800, 0, 1);
        idle(8, 1);
        for (int i = 0; i < 8; i++) pix(i / 4, i % 4, 16'h3100 + 16'(i), 16'h3800, 1, 1);
        idle(5, 1);
        @(negedge clk); chk("ovf_sticky", {63'd0, overflow_o}, 64'd1);

        // push and pop at full
        do_reset();
        for (int i = 0; i < 5; i++) pix(i / 4, i % 4, 16'h5000 + 16'(i), 16'h3800, 1, 0);
        for (int i = 5; i < 8; i++) pix(i / 4, i % 4, 16'h5000 + 16'(i), 16'h3800, 1, 1);
        idle(8, 1);
        @(negedge clk); chk("full_pp_ovf", {63'd0, overflow_o}, 64'd0);

        // confidence masking (z zeroed only when the macro is built in)
        for (int i = 0; i < 8; i++)
            pix(i / 4, i % 4, (i % 2 == 0) ? 16'h4000 : 16'h4000 + 16'(i),
                (i % 2 == 0) ? 16'h3400 : 16'h3800, 1, 1);
        idle(2, 1);

        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dfdd_result_streamer.md
# dfdd_result_streamer

- Receive-side consumer of the single-scale V/W divider output stream.
- Accepts the valid-only pixel stream (z, confidence c, col, row), which has no backpressure.
- Buffers pixels in a FIFO and re-emits them as a ready/valid stream with start-of-frame and end-of-line markers.
- Sits between the DfDD divider stage and the frame writer / host link; detects overflow and resynchronises on frame boundaries.

## Interface
Parameters:
- EXP_WIDTH, 0, floating-point exponent width
- FRAC_WIDTH, 0, floating-point fraction width
- IMAGE_WIDTH, 640, pixels per row
- IMAGE_HEIGHT, 480, rows per frame
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥ 4
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, local parameter, not to be overridden

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  synchronous, active-high reset
- z_i  in  FP_WIDTH_REG  depth estimate
- c_i  in  FP_WIDTH_REG  confidence; sign bit is always 0
- col_i  in  16  pixel column
- row_i  in  16  pixel row
- valid_i  in  1  input pixel qualifier; no ready is returned
- c_thresh_i  in  FP_WIDTH_REG  confidence threshold; used only with the macro
- data_o  out  2*FP_WIDTH_REG  {c, z}, with c in the upper half
- sof_o  out  1  pixel is row 0, col 0
- eol_o  out  1  pixel is col IMAGE_WIDTH-1
- valid_o  out  1  output qualifier
- ready_i  in  1  downstream accept
- overflow_o  out  1  sticky; a pixel was dropped because the FIFO was full
- frame_done_o  out  1  one-cycle pulse when the last pixel of a frame is accepted downstream

## Operation
State machine (input side):
- **WAIT_SOF**
  - Discard input until a valid_i pixel with row_i=0 and col_i=0 arrives.
  - Push that pixel and go to STREAM.
- **STREAM**
  - Push every valid_i pixel.
  - On pushing the pixel with row=IMAGE_HEIGHT-1 and col=IMAGE_WIDTH-1, return to WAIT_SOF.
  - On valid_i while full (see push rule below), drop the pixel, set overflow_o, go to DROP.
- **DROP**
  - Discard input exactly as in WAIT_SOF.
  - A row 0 / col 0 pixel is pushed and moves the block to STREAM; overflow_o stays set.

FIFO behaviour:
- Each entry holds {c, z, sof, eol}.
- sof and eol are computed from row_i/col_i at push time.
- Push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle (push and pop at full: both occur, count unchanged).
- Pop occurs when valid_o && ready_i.

Output register:
- Holds the head entry.
- data_o, sof_o and eol_o stay stable while valid_o && !ready_i.
- valid_o never deasserts without a handshake.

frame_done_o:
- Asserts in the cycle after the handshake of an entry that has eol=1 and was pushed as the last pixel of the frame (a tagged bit in the entry).

Arithmetic:
- No floating-point arithmetic in the block.
- c comparison (macro only) is an unsigned compare of bits [FP_WIDTH_REG-2:0], valid because c is non-negative.

Reset (rst_i high at a clock edge):
- FIFO empty, state WAIT_SOF.
- valid_o=0, data_o=0, sof_o=0, eol_o=0, overflow_o=0, frame_done_o=0.
- Reset mid-frame discards all buffered pixels. The next accepted pixel must be row 0 / col 0.

## Timing
- Latency: a pixel sampled at edge k with the FIFO empty and the output register empty gives valid_o=1 after edge k+1 (1 cycle).
- Throughput: one pixel per cycle sustained while ready_i=1; no bubbles.
- Full FIFO plus output register holds FIFO_DEPTH+1 pixels.
- overflow_o rises after the edge that sampled the dropped pixel.
- frame_done_o is high for exactly one cycle.

## Configuration
Macro DFDD_CONF_MASK_EN:
- **Defined**
  - At push time, if c_i < c_thresh_i, the stored z is replaced with 0 (all bits zero).
  - c is stored unchanged.
- **Undefined**
  - z_i is stored unmodified and c_thresh_i is ignored.
  - No comparator is synthesised.

## Test plan
Use EXP_WIDTH=5, FRAC_WIDTH=10, IMAGE_WIDTH=4, IMAGE_HEIGHT=2, FIFO_DEPTH=4 throughout.
- **Frame pass-through:** one frame of 8 pixels with z=16'h3C00 and c=16'h3800, ready_i=1 → 8 outputs with data_o=32'h3800_3C00; sof_o on the 1st output; eol_o on the 4th and 8th; frame_done_o pulses once after the 8th; latency 1 cycle.
- **Startup discard:** after reset, pixels (0,1),(0,2) then (0,0) → only the pixel from (0,0) onward is output; overflow_o=0.
- **Backpressure:** ready_i=0 for 5 pixels → 5 pixels buffered, no drop; release → all 5 output in order with data held stable while stalled.
- **Overflow:** ready_i=0 and 6 pixels pushed → 6th is dropped; overflow_o=1 stays set; the rest of the frame is discarded; the next frame's (0,0) resumes output.
- **Push/pop at full:** 5 pixels buffered, then ready_i=1 with a 6th pixel in the same cycle → no drop; overflow_o=0.
- **Masking (macro defined):** c_thresh_i=16'h3800, c_i=16'h3400, z_i=16'h4000 → data_o=32'h3400_0000. With c_i=16'h3800 → z is passed unchanged.
